// File: rtl/delay_compare_checker.sv
// Delays a reference stream by a runtime-selected depth and compares it with a DUT stream.
// Counts compares and mismatches, and latches the first mismatching pair.
module delay_compare_checker #(
  parameter int WIDTH     = 8,
  parameter int MAX_DELAY = 8,
  parameter int CNT_WIDTH = 16,
  parameter int DSEL_W    = $clog2(MAX_DELAY + 1)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 enable,
  input  logic                 clear,
  input  logic [DSEL_W-1:0]    delay_sel,
  input  logic                 ref_valid,
  input  logic [WIDTH-1:0]     ref_data,
  input  logic [WIDTH-1:0]     dut_data,
  output logic                 equal,
  output logic                 match_pulse,
  output logic                 mismatch_pulse,
  output logic [CNT_WIDTH-1:0] compare_count,
  output logic [CNT_WIDTH-1:0] mismatch_count,
  output logic                 error,
  output logic [WIDTH-1:0]     first_exp,
  output logic [WIDTH-1:0]     first_got,
  output logic                 armed
);

  logic [DSEL_W-1:0]    d_eff;
  logic [DSEL_W-1:0]    d_reg;
  logic [DSEL_W-1:0]    fill_reg;
  logic                 flush;
  logic                 valid_reg [MAX_DELAY];
  logic [WIDTH-1:0]     data_reg  [MAX_DELAY];
  logic                 tap_valid;
  logic [WIDTH-1:0]     tap_data;
  logic                 tap_match;
  logic                 qualified;
  logic                 match_pulse_reg;
  logic                 mismatch_pulse_reg;
  logic [CNT_WIDTH-1:0] compare_count_reg;
  logic [CNT_WIDTH-1:0] mismatch_count_reg;
  logic                 error_reg;
  logic [WIDTH-1:0]     first_exp_reg;
  logic [WIDTH-1:0]     first_got_reg;

  always_comb begin
    d_eff = delay_sel;
    if (delay_sel == '0) begin
      d_eff = DSEL_W'(1);
    end else if (delay_sel > DSEL_W'(MAX_DELAY)) begin
      d_eff = DSEL_W'(MAX_DELAY);
    end
  end

  // A new latency invalidates everything in flight, so stale data is never compared.
  assign flush = (d_eff != d_reg);

  always_ff @(posedge clk) begin
    if (rst) begin
      d_reg    <= d_eff;
      fill_reg <= '0;
    end else begin
      d_reg <= d_eff;
      if (flush) begin
        fill_reg <= '0;
      end else if (fill_reg != DSEL_W'(MAX_DELAY)) begin
        fill_reg <= fill_reg + DSEL_W'(1);
      end
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < MAX_DELAY; gi++) begin : g_stage
      logic             in_valid;
      logic [WIDTH-1:0] in_data;
      if (gi == 0) begin : g_head
        assign in_valid = ref_valid;
        assign in_data  = ref_data;
      end else begin : g_body
        assign in_valid = valid_reg[gi-1];
        assign in_data  = data_reg[gi-1];
      end
      always_ff @(posedge clk) begin
        if (rst) begin
          valid_reg[gi] <= 1'b0;
          data_reg[gi]  <= '0;
        end else begin
          valid_reg[gi] <= in_valid & ~flush;
          data_reg[gi]  <= in_data;
        end
      end
    end
  endgenerate

  always_comb begin
    tap_valid = 1'b0;
    tap_data  = '0;
    for (int k = 0; k < MAX_DELAY; k++) begin
      if (d_eff == DSEL_W'(k + 1)) begin
        tap_valid = valid_reg[k];
        tap_data  = data_reg[k];
      end
    end
  end

  assign tap_match = (tap_data == dut_data);
  assign armed     = (fill_reg >= d_eff);
  assign equal     = ~tap_valid | tap_match;
  assign qualified = enable & tap_valid & armed;

  // clear outranks a same-cycle compare: its pulse, count and capture are dropped.
  always_ff @(posedge clk) begin
    if (rst || clear) begin
      match_pulse_reg    <= 1'b0;
      mismatch_pulse_reg <= 1'b0;
      compare_count_reg  <= '0;
      mismatch_count_reg <= '0;
      error_reg          <= 1'b0;
      first_exp_reg      <= '0;
      first_got_reg      <= '0;
    end else begin
      match_pulse_reg    <= qualified & tap_match;
      mismatch_pulse_reg <= qualified & ~tap_match;
      if (qualified && compare_count_reg != '1) begin
        compare_count_reg <= compare_count_reg + CNT_WIDTH'(1);
      end
      if (qualified && !tap_match) begin
        if (mismatch_count_reg != '1) begin
          mismatch_count_reg <= mismatch_count_reg + CNT_WIDTH'(1);
        end
        if (!error_reg) begin
          error_reg     <= 1'b1;
          first_exp_reg <= tap_data;
          first_got_reg <= dut_data;
        end
      end
    end
  end

  assign match_pulse    = match_pulse_reg;
  assign mismatch_pulse = mismatch_pulse_reg;
  assign compare_count  = compare_count_reg;
  assign mismatch_count = mismatch_count_reg;
  assign error          = error_reg;
  assign first_exp      = first_exp_reg;
  assign first_got      = first_got_reg;

endmodule

// File: tb/tb_delay_compare_checker.sv
// Bench for delay_compare_checker: latency-model DUT, per-cycle pulse scoreboard, phase-end count checks.
module tb_delay_compare_checker;

  localparam int WIDTH     = 8;
  localparam int MAX_DELAY = 8;
  localparam int CNT_WIDTH = 16;
  localparam int SAT_CNT_W = 4;
  localparam int DSEL_W    = $clog2(MAX_DELAY + 1);

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              rst, enable, clear, ref_valid;
  logic [DSEL_W-1:0] delay_sel;
  logic [WIDTH-1:0]  ref_data, dut_data, sat_dut_data;

  logic                 equal, match_pulse, mismatch_pulse, error, armed;
  logic [CNT_WIDTH-1:0] compare_count, mismatch_count;
  logic [WIDTH-1:0]     first_exp, first_got;

  logic                 sat_equal, sat_match_pulse, sat_mismatch_pulse, sat_error, sat_armed;
  logic [SAT_CNT_W-1:0] sat_compare_count, sat_mismatch_count;
  logic [WIDTH-1:0]     sat_first_exp, sat_first_got;

  delay_compare_checker #(.WIDTH(WIDTH), .MAX_DELAY(MAX_DELAY), .CNT_WIDTH(CNT_WIDTH)) u_dut (
    .clk(clk), .rst(rst), .enable(enable), .clear(clear), .delay_sel(delay_sel),
    .ref_valid(ref_valid), .ref_data(ref_data), .dut_data(dut_data),
    .equal(equal), .match_pulse(match_pulse), .mismatch_pulse(mismatch_pulse),
    .compare_count(compare_count), .mismatch_count(mismatch_count), .error(error),
    .first_exp(first_exp), .first_got(first_got), .armed(armed)
  );

  delay_compare_checker #(.WIDTH(WIDTH), .MAX_DELAY(MAX_DELAY), .CNT_WIDTH(SAT_CNT_W)) u_sat (
    .clk(clk), .rst(rst), .enable(enable), .clear(clear), .delay_sel(delay_sel),
    .ref_valid(ref_valid), .ref_data(ref_data), .dut_data(sat_dut_data),
    .equal(sat_equal), .match_pulse(sat_match_pulse), .mismatch_pulse(sat_mismatch_pulse),
    .compare_count(sat_compare_count), .mismatch_count(sat_mismatch_count), .error(sat_error),
    .first_exp(sat_first_exp), .first_got(sat_first_got), .armed(sat_armed)
  );

  typedef struct packed {
    logic m;
    logic mm;
  } exp_t;

  exp_t            sb_q[$];
  int              checks = 0;
  int              errors = 0;
  bit              hv [1:16];
  logic [WIDTH-1:0] hd [1:16];
  int              age, d_model, lat, mode, mis_seen, armed_low;
  bit              model_ok;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic int clampd(input logic [DSEL_W-1:0] s);
    if (s == '0) return 1;
    if (int'(s) > MAX_DELAY) return MAX_DELAY;
    return int'(s);
  endfunction

  // One clock: drive the DUT model, check combinational outputs, predict and check the pulses.
  task automatic drive_cycle();
    int               d;
    bit               tv, tm, q, rst_s, rv_s;
    logic [WIDTH-1:0] model_out, rd_s;
    exp_t             e;
    d = clampd(delay_sel);
    model_out = hd[lat];
    dut_data  = model_out;
    if (mode == 1 && model_out == 8'h2A)      dut_data = 8'h2B;
    else if (mode == 1 && model_out == 8'h40) dut_data = 8'h41;
    else if (mode == 2)                       dut_data = ~model_out;
    sat_dut_data = ~model_out;
    @(negedge clk);
    tv = (age >= d) && hv[d];
    tm = (hd[d] == dut_data);
    q  = enable && tv;
    if (model_ok) begin
      check("armed", armed, age >= d);
      check("equal", equal, !tv || tm);
      if (!armed) armed_low++;
    end
    e.m  = !rst && !clear && q && tm;
    e.mm = !rst && !clear && q && !tm;
    sb_q.push_back(e);
    rst_s = rst;
    rv_s  = ref_valid;
    rd_s  = ref_data;
    @(posedge clk);
    #1;
    for (int k = 16; k >= 2; k--) begin
      hd[k] = hd[k-1];
      hv[k] = hv[k-1];
    end
    hd[1] = rd_s;
    hv[1] = rv_s;
    if (rst_s) begin
      age = 0; d_model = d; model_ok = 1'b1;
    end else if (d != d_model) begin
      age = 0; d_model = d;
    end else begin
      age++;
    end
    e = sb_q.pop_front();
    check("match_pulse", match_pulse, e.m);
    check("mismatch_pulse", mismatch_pulse, e.mm);
    if (mismatch_pulse) mis_seen++;
  endtask

  task automatic idle(input int n, input bit clear_last);
    for (int i = 0; i < n; i++) begin
      ref_valid = 1'b0;
      ref_data  = '0;
      clear     = clear_last && (i == n - 1);
      drive_cycle();
    end
    clear = 1'b0;
  endtask

  task automatic stream(input int base, input int n, input int clear_at);
    for (int j = 0; j < n; j++) begin
      ref_valid = 1'b1;
      ref_data  = WIDTH'(base + j);
      clear     = (j == clear_at);
      drive_cycle();
    end
    clear = 1'b0;
  endtask

  task automatic check_reset_state(input string pfx);
    check({pfx, "_compare_count"}, compare_count, 0);
    check({pfx, "_mismatch_count"}, mismatch_count, 0);
    check({pfx, "_error"}, error, 0);
    check({pfx, "_first_exp"}, first_exp, 0);
    check({pfx, "_first_got"}, first_got, 0);
    check({pfx, "_equal"}, equal, 1);
    check({pfx, "_armed"}, armed, 0);
  endtask

  initial begin
    #2000000;
    $display("FAIL timeout");
    $fatal(1);
  end

  initial begin
    for (int k = 1; k <= 16; k++) begin
      hv[k] = 1'b0;
      hd[k] = '0;
    end
    age = 0; d_model = 3; lat = 3; mode = 0; mis_seen = 0; armed_low = 0; model_ok = 1'b0;
    rst = 1'b1; enable = 1'b0; clear = 1'b0; delay_sel = DSEL_W'(3);
    ref_valid = 1'b0; ref_data = '0; dut_data = '0; sat_dut_data = '0;

    // Reset values
    drive_cycle();
    drive_cycle();
    check_reset_state("reset");
    rst = 1'b0;
    enable = 1'b1;

    // Pass-through ramp at D=3; saturating instance sees only mismatches
    mis_seen = 0;
    stream(0, 100, -1);
    idle(6, 1'b0);
    check("pass_compare_count", compare_count, 100);
    check("pass_mismatch_count", mismatch_count, 0);
    check("pass_error", error, 0);
    check("pass_mismatch_pulses", mis_seen, 0);
    check("sat_mismatch_count", sat_mismatch_count, 15);
    check("sat_compare_count", sat_compare_count, 15);
    check("sat_error", sat_error, 1);

    // Single faults at D=5
    delay_sel = DSEL_W'(5); lat = 5; mode = 1;
    idle(10, 1'b1);
    mis_seen = 0;
    stream(8'h20, 48, -1);
    idle(8, 1'b0);
    check("fault_compare_count", compare_count, 48);
    check("fault_mismatch_count", mismatch_count, 2);
    check("fault_mismatch_pulses", mis_seen, 2);
    check("fault_error", error, 1);
    check("fault_first_exp", first_exp, 8'h2A);
    check("fault_first_got", first_got, 8'h2B);

    // Delay change 2 -> 6 mid-stream
    delay_sel = DSEL_W'(2); lat = 2; mode = 0;
    idle(10, 1'b1);
    stream(8'h60, 20, -1);
    delay_sel = DSEL_W'(6); lat = 6;
    armed_low = 0;
    stream(8'h74, 30, -1);
    idle(10, 1'b0);
    check("dchg_armed_low_cycles", armed_low, 6);
    check("dchg_mismatch_count", mismatch_count, 0);
    check("dchg_error", error, 0);

    // clear coincident with a mismatch, then rst mid-stream
    delay_sel = DSEL_W'(3); lat = 3; mode = 2;
    idle(10, 1'b1);
    stream(8'h80, 9, 8);
    check("clr_compare_count", compare_count, 0);
    check("clr_mismatch_count", mismatch_count, 0);
    check("clr_error", error, 0);
    check("clr_first_exp", first_exp, 0);
    check("clr_first_got", first_got, 0);
    stream(8'h89, 6, -1);
    check("pre_rst_error", error, 1);
    rst = 1'b1;
    ref_valid = 1'b1;
    ref_data = 8'h99;
    drive_cycle();
    check_reset_state("midrst");
    rst = 1'b0;
    mode = 0;
    armed_low = 0;
    stream(8'hA0, 10, -1);
    check("midrst_armed_low_cycles", armed_low, 3);
    check("midrst_error", error, 0);

    // Clamping: 0 -> D=1, MAX_DELAY+3 -> D=MAX_DELAY
    delay_sel = DSEL_W'(0); lat = 1;
    idle(10, 1'b1);
    stream(8'h10, 20, -1);
    idle(10, 1'b0);
    check("clamp0_compare_count", compare_count, 20);
    check("clamp0_mismatch_count", mismatch_count, 0);
    delay_sel = DSEL_W'(MAX_DELAY + 3); lat = MAX_DELAY;
    idle(10, 1'b1);
    stream(8'hC0, 20, -1);
    idle(10, 1'b0);
    check("clamphi_compare_count", compare_count, 20);
    check("clamphi_mismatch_count", mismatch_count, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/delay_compare_checker.md
# delay_compare_checker

Parametrised self-checking comparator for the verification harness. It delays a reference stream through a runtime-selectable pipeline depth and compares it against a DUT output stream. It counts compares and mismatches, holds a sticky error flag, and captures the first mismatching pair. It sits beside a DUT whose latency is 1..MAX_DELAY cycles: the reference input taps the DUT stimulus and the observed input taps the DUT result.

## Interface
- WIDTH, 8, data width of both streams
- MAX_DELAY, 8, deepest supported delay in cycles (≥1)
- CNT_WIDTH, 16, width of the saturating counters
- DSEL_W, $clog2(MAX_DELAY+1), width of delay_sel (derived)

- clk  in  1  single clock; all state updates on rising edge
- rst  in  1  synchronous, active-high reset
- enable  in  1  compare enable; the pipeline shifts regardless
- clear  in  1  one-cycle pulse; zeroes counters, error and capture; pipeline untouched
- delay_sel  in  DSEL_W  DUT latency D; 0 treated as 1, values >MAX_DELAY treated as MAX_DELAY
- ref_valid  in  1  ref_data is meaningful this cycle
- ref_data  in  WIDTH  stimulus to be delayed
- dut_data  in  WIDTH  DUT output, already delayed by the DUT
- equal  out  1  combinational: 1 if the tap is invalid, else (tap data == dut_data)
- match_pulse  out  1  registered: a qualified compare matched last cycle
- mismatch_pulse  out  1  registered: a qualified compare mismatched last cycle
- compare_count  out  CNT_WIDTH  saturating count of qualified compares
- mismatch_count  out  CNT_WIDTH  saturating count of mismatches
- error  out  1  sticky; set on first mismatch
- first_exp  out  WIDTH  expected value at the first mismatch
- first_got  out  WIDTH  observed value at the first mismatch
- armed  out  1  the pipeline holds ≥D valid-tracked stages since the last flush

## Operation
- Pipeline: MAX_DELAY stages of {valid, data}. Stage 1 loads {ref_valid, ref_data} every cycle; stage k loads stage k-1. It shifts every cycle and never stalls.
- Tap: stage D, where D is the effective (clamped) delay_sel.
- Qualified compare: enable & tap_valid & armed.
- Matching qualified compare: next cycle match_pulse=1 and compare_count+1.
- Mismatching qualified compare: next cycle mismatch_pulse=1, compare_count+1 and mismatch_count+1. If error=0, error<=1, first_exp<=tap data and first_got<=dut_data. Later mismatches do not overwrite the capture.
- Counters saturate at 2^CNT_WIDTH-1 and never wrap.
- delay_sel change: the block registers the effective D. When it differs from the registered value, all valid bits clear and the fill counter resets to 0 in the same edge. Counters and error are kept.
- Fill counter: increments each cycle up to MAX_DELAY. armed = (fill ≥ D). This blocks compares against stale data after reset or a delay change.
- clear: counters, error, first_exp, first_got and both pulses go to 0 on the next edge. clear has priority over a compare in the same cycle: that compare's pulse, count and capture are all dropped.
- enable=0: no pulses, no counts and no capture. equal is still driven.

## Timing
- Reset values: pipeline data and valid = 0; fill = 0; armed = 0; match_pulse = mismatch_pulse = 0; compare_count = mismatch_count = 0; error = 0; first_exp = first_got = 0; equal = 1 (the tap is invalid).
- A ref_data sampled at edge t is at the tap during cycle t+D-1 and is compared against dut_data presented in that cycle. That is the value the DUT registers D edges after the stimulus.
- D=3 reproduces the legacy fixed-three-stage checker timing.
- Pulses and counters lag the compare by 1 cycle. error is visible 1 cycle after the first mismatch.
- armed rises D cycles after reset deassertion or a delay change.
- rst during operation: everything returns to reset values on that edge, with re-fill required.

## Test plan
- Pass-through, WIDTH=8, D=3. Feed a 3-register DUT model with ramp 0..99, ref_valid=1. Required: 100 qualified compares counted (compare_count=100), mismatch_count=0, error=0, no mismatch_pulse.
- Single fault, D=5. Corrupt the DUT output for ref value 0x2A so 0x2B arrives. Required: mismatch_pulse for exactly 1 cycle, error=1 from then on, first_exp=0x2A, first_got=0x2B. A second fault at 0x40 leaves the capture unchanged and gives mismatch_count=2.
- Delay change mid-stream, D 2->6. Required: armed drops for 6 cycles with no compares and no pulses in that window. With a 6-cycle DUT model, compares resume with zero mismatches.
- Saturation, CNT_WIDTH=4, all mismatches. Required: mismatch_count holds at 15 and does not wrap.
- clear coincident with a mismatch, then rst mid-stream. Required: the post-clear counts, error and capture are all 0. After rst, all outputs are at reset values and armed is 0 until D cycles elapse.
- Clamping. delay_sel=0 behaves as D=1; delay_sel=MAX_DELAY+3 behaves as D=MAX_DELAY.
